// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: stage-0 pixel request address, 2-stage sync/DE/RGB output pipeline.
// Optional VGA_TEST_PATTERN_EN replaces rgb_i with eight 80-px colour bars.
`ifndef COLOR_GRAY_DEPTH
`define COLOR_GRAY_DEPTH 4
`endif
`ifndef COLOR_RGB_DEPTH
`define COLOR_RGB_DEPTH 12
`endif
`ifndef H_DISP_LEN
`define H_DISP_LEN 10
`endif
`ifndef V_DISP_LEN
`define V_DISP_LEN 10
`endif

module vga_timing_gen #(
  parameter int H_DISP  = 640,
  parameter int H_FRONT = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int V_DISP  = 480,
  parameter int V_FRONT = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33
) (
  input  logic                        clk_vga,
  input  logic                        rst,
  input  logic [`COLOR_RGB_DEPTH-1:0] rgb_i,
  output logic [`H_DISP_LEN-1:0]      req_x_addr_o,
  output logic [`V_DISP_LEN-1:0]      req_y_addr_o,
  output logic                        req_en_o,
  output logic                        frame_start_o,
  output logic                        h_sync_o,
  output logic                        v_sync_o,
  output logic                        de_o,
  output logic [`COLOR_RGB_DEPTH-1:0] rgb_o
);

  localparam int H_TOTAL = H_DISP + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISP + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int XW = `H_DISP_LEN;
  localparam int YW = `V_DISP_LEN;
  localparam int RW = `COLOR_RGB_DEPTH;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_DISP_C = HW'(H_DISP);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_DISP + H_FRONT);
  localparam logic [HW-1:0] HS_END   = HW'(H_DISP + H_FRONT + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_DISP_C = VW'(V_DISP);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_DISP + V_FRONT);
  localparam logic [VW-1:0] VS_END   = VW'(V_DISP + V_FRONT + V_SYNC - 1);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          hs_raw, vs_raw, de_raw;
  logic          hs1, vs1, de1;
  logic [RW-1:0] pix;

  // Stage 0: free-running raster counters; both wrap together on the last pixel of a frame.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  assign de_raw = (h_cnt < H_DISP_C) && (v_cnt < V_DISP_C);
  assign hs_raw = (h_cnt >= HS_BEG) && (h_cnt <= HS_END);
  assign vs_raw = (v_cnt >= VS_BEG) && (v_cnt <= VS_END);

  // All-ones outside the active area keeps every sprite position compare from matching.
  assign req_en_o      = de_raw;
  assign req_x_addr_o  = de_raw ? XW'(h_cnt) : '1;
  assign req_y_addr_o  = de_raw ? YW'(v_cnt) : '1;
  assign frame_start_o = (h_cnt == '0) && (v_cnt == '0);

  // Stage 1: raw flags, aligned with the BRAM read data arriving on rgb_i.
  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      hs1 <= 1'b0;
      vs1 <= 1'b0;
      de1 <= 1'b0;
    end else begin
      hs1 <= hs_raw;
      vs1 <= vs_raw;
      de1 <= de_raw;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int GW = `COLOR_GRAY_DEPTH;
  logic [XW-1:0] x1;
  logic [2:0]    bar;

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) x1 <= '0;
    else     x1 <= req_x_addr_o;
  end

  // Bar index by threshold compare chain; the last satisfied threshold wins.
  // NOTE: bar gets its default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    bar = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (x1 >= XW'(80 * i)) bar = 3'(i);
    end
  end

  assign pix = {{GW{bar[2]}}, {GW{bar[1]}}, {GW{bar[0]}}};
`else
  assign pix = rgb_i;
`endif

  // Stage 2: pad registers; syncs are active-low and idle high in reset.
  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      h_sync_o <= 1'b1;
      v_sync_o <= 1'b1;
      de_o     <= 1'b0;
      rgb_o    <= '0;
    end else begin
      h_sync_o <= ~hs1;
      v_sync_o <= ~vs1;
      de_o     <= de1;
      rgb_o    <= de1 ? pix : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: horizontal timing at full 800-cycle lines,
// vertical timing on a shortened 13-line frame so several frames fit in a short run.
module tb_vga_timing_gen;

  localparam int VD = 6, VF = 2, VS = 2, VB = 3;
  localparam int HT = 800, VT = VD + VF + VS + VB;
  localparam int FRAME  = HT * VT;
  localparam int HOLD_K = FRAME + 1600;
  localparam int RST_K  = 2 * FRAME + 3 * HT + 300;

  logic        clk_vga = 1'b0;
  logic        rst;
  logic [11:0] rgb_i;
  logic [9:0]  req_x_addr_o, req_y_addr_o;
  logic        req_en_o, frame_start_o, h_sync_o, v_sync_o, de_o;
  logic [11:0] rgb_o;

  vga_timing_gen #(
    .V_DISP(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk_vga(clk_vga), .rst(rst), .rgb_i(rgb_i),
    .req_x_addr_o(req_x_addr_o), .req_y_addr_o(req_y_addr_o),
    .req_en_o(req_en_o), .frame_start_o(frame_start_o),
    .h_sync_o(h_sync_o), .v_sync_o(v_sync_o), .de_o(de_o), .rgb_o(rgb_o)
  );

  always #5 clk_vga = ~clk_vga;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected pad colour for a visible column: BRAM model returns the column, hold mode all-ones.
  function automatic logic [11:0] exp_pix(input int col, input bit hold);
`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] b;
    b = 3'(col / 80);
    return {{4{b[2]}}, {4{b[1]}}, {4{b[0]}}};
`else
    return hold ? 12'hFFF : 12'(col);
`endif
  endfunction

  typedef struct {
    int         cyc;
    logic [9:0] x;
    logic [9:0] y;
    logic       en, fs, hs, vs, de;
    int         col;
  } vec_t;

  vec_t vecs [24];

  initial begin
    logic [9:0] last_req;
    logic       prev_hs, prev_de;
    int vi, req_err, out_err, de_cnt, hs_low, vs_low, hs_rise, de_rise, n, de_cnt2;
    int hs_fall[$];
    int fs_seen[$];

    //          cyc    x        y        en fs hs vs de col
    vecs = '{'{    0, 10'd0,   10'd0,   1, 1, 1, 1, 0, -1},
             '{    1, 10'd1,   10'd0,   1, 0, 1, 1, 0, -1},
             '{    2, 10'd2,   10'd0,   1, 0, 1, 1, 1,  0},
             '{    5, 10'd5,   10'd0,   1, 0, 1, 1, 1,  3},
             '{  639, 10'd639, 10'd0,   1, 0, 1, 1, 1, 637},
             '{  640, 10'h3FF, 10'h3FF, 0, 0, 1, 1, 1, 638},
             '{  641, 10'h3FF, 10'h3FF, 0, 0, 1, 1, 1, 639},
             '{  642, 10'h3FF, 10'h3FF, 0, 0, 1, 1, 0, -1},
             '{  657, 10'h3FF, 10'h3FF, 0, 0, 1, 1, 0, -1},
             '{  658, 10'h3FF, 10'h3FF, 0, 0, 0, 1, 0, -1},
             '{  753, 10'h3FF, 10'h3FF, 0, 0, 0, 1, 0, -1},
             '{  754, 10'h3FF, 10'h3FF, 0, 0, 1, 1, 0, -1},
             '{  800, 10'd0,   10'd1,   1, 0, 1, 1, 0, -1},
             '{  802, 10'd2,   10'd1,   1, 0, 1, 1, 1,  0},
             '{  803, 10'd3,   10'd1,   1, 0, 1, 1, 1,  1},
             '{ 4800, 10'h3FF, 10'h3FF, 0, 0, 1, 1, 0, -1},
             '{ 4802, 10'h3FF, 10'h3FF, 0, 0, 1, 1, 0, -1},
             '{ 6401, 10'h3FF, 10'h3FF, 0, 0, 1, 1, 0, -1},
             '{ 6402, 10'h3FF, 10'h3FF, 0, 0, 1, 0, 0, -1},
             '{ 8001, 10'h3FF, 10'h3FF, 0, 0, 1, 0, 0, -1},
             '{ 8002, 10'h3FF, 10'h3FF, 0, 0, 1, 1, 0, -1},
             '{10399, 10'h3FF, 10'h3FF, 0, 0, 1, 1, 0, -1},
             '{10400, 10'd0,   10'd0,   1, 1, 1, 1, 0, -1},
             '{10402, 10'd2,   10'd0,   1, 0, 1, 1, 1,  0}};

    rst = 1'b1;
    rgb_i = '0;
    last_req = '0;
    repeat (3) @(negedge clk_vga);
    check("rst_outputs", {h_sync_o, v_sync_o, de_o, rgb_o}, {1'b1, 1'b1, 1'b0, 12'h000});
    check("rst_request", {req_x_addr_o, req_y_addr_o, req_en_o, frame_start_o},
          {10'd0, 10'd0, 1'b1, 1'b1});

    rst = 1'b0;
    vi = 0; req_err = 0; out_err = 0; de_cnt = 0; hs_low = 0; vs_low = 0;
    hs_rise = -1; de_rise = -1; prev_hs = 1'b1; prev_de = 1'b0;

    for (int k = 0; k <= RST_K; k++) begin
      int h, v, ph, pv;
      logic e_en, e_hs, e_vs, e_de;
      logic [9:0] e_x, e_y;
      logic [11:0] e_rgb;
      if (k > 0) @(negedge clk_vga);

      // Stage-0 request model from absolute cycle position.
      h = k % HT; v = (k / HT) % VT;
      e_en = (h < 640) && (v < VD);
      e_x  = e_en ? 10'(h) : 10'h3FF;
      e_y  = e_en ? 10'(v) : 10'h3FF;
      if ({req_x_addr_o, req_y_addr_o, req_en_o, frame_start_o} !==
          {e_x, e_y, e_en, (h == 0 && v == 0)}) begin
        if (req_err == 0) $display("first request deviation at cycle %0d", k);
        req_err++;
      end

      // Output model: the request issued two cycles earlier.
      if (k < 2) begin
        e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_rgb = '0;
      end else begin
        ph = (k - 2) % HT; pv = ((k - 2) / HT) % VT;
        e_hs  = !(ph >= 656 && ph <= 751);
        e_vs  = !(pv >= VD + VF && pv <= VD + VF + VS - 1);
        e_de  = (ph < 640) && (pv < VD);
        e_rgb = e_de ? exp_pix(ph, k >= HOLD_K + 1) : 12'h000;
      end
      if ({h_sync_o, v_sync_o, de_o, rgb_o} !== {e_hs, e_vs, e_de, e_rgb}) begin
        if (out_err == 0) $display("first output deviation at cycle %0d", k);
        out_err++;
      end

      if (vi < 24 && vecs[vi].cyc == k) begin
        check($sformatf("vec_cycle_%0d", k),
              {req_x_addr_o, req_y_addr_o, req_en_o, frame_start_o, h_sync_o, v_sync_o, de_o, rgb_o},
              {vecs[vi].x, vecs[vi].y, vecs[vi].en, vecs[vi].fs, vecs[vi].hs, vecs[vi].vs, vecs[vi].de,
               (vecs[vi].col < 0) ? 12'h000 : exp_pix(vecs[vi].col, 1'b0)});
        vi++;
      end

      if (k >= 2 && k < 2 + FRAME) begin
        de_cnt += int'(de_o);
        hs_low += int'(!h_sync_o);
        vs_low += int'(!v_sync_o);
      end
      if (prev_hs && !h_sync_o) hs_fall.push_back(k);
      if (!prev_hs && h_sync_o && hs_rise < 0) hs_rise = k;
      if (!prev_de && de_o && de_rise < 0) de_rise = k;
      if (frame_start_o) fs_seen.push_back(k);
      prev_hs = h_sync_o;
      prev_de = de_o;

      // BRAM model: data for last cycle's request, or all-ones once hold mode starts.
      rgb_i = (k >= HOLD_K) ? 12'hFFF : {2'b00, last_req};
      last_req = req_x_addr_o;
    end

    check("vectors_applied", vi, 24);
    check("request_stream_errors", req_err, 0);
    check("output_stream_errors", out_err, 0);
    check("hs_first_fall", (hs_fall.size() > 0) ? hs_fall[0] : -1, 658);
    check("hs_period", (hs_fall.size() > 1) ? hs_fall[1] - hs_fall[0] : -1, 800);
    check("hs_pulse_width", (hs_fall.size() > 0) ? hs_rise - hs_fall[0] : -1, 96);
    check("de_cycles_per_frame", de_cnt, 640 * VD);
    check("hs_low_per_frame", hs_low, 96 * VT);
    check("vs_low_per_frame", vs_low, 1600);
    check("first_de_after_fs", de_rise, 2);
    check("frame_starts_seen", fs_seen.size(), 3);
    check("frame_period", (fs_seen.size() > 1) ? fs_seen[1] - fs_seen[0] : -1, FRAME);

    // Mid-frame asynchronous reset at line 3, column 300, between clock edges.
    check("pre_reset_de", de_o, 1'b1);
    check("pre_reset_rgb", rgb_o, exp_pix(298, 1'b1));
    #2 rst = 1'b1;
    #1;
    check("arst_outputs", {h_sync_o, v_sync_o, de_o, rgb_o}, {1'b1, 1'b1, 1'b0, 12'h000});
    check("arst_request", {req_x_addr_o, req_y_addr_o, req_en_o, frame_start_o},
          {10'd0, 10'd0, 1'b1, 1'b1});
    repeat (2) @(negedge clk_vga);
    rst = 1'b0;
    check("release_frame_start", frame_start_o, 1'b1);
    n = 0; de_cnt2 = 0;
    do begin
      @(negedge clk_vga);
      n++;
      de_cnt2 += int'(de_o);
    end while (!frame_start_o && n < FRAME + 50);
    check("post_reset_frame_len", n, FRAME);
    check("post_reset_de_cycles", de_cnt2, 640 * VD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
